// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants, event type and scancode->ASCII helper for the PS/2 key decoder
//
// Purpose : FSM state encodings, set-2 prefix / modifier scancodes, the packed
//           key event carried through the event FIFO, and the ASCII lookup.
// Ports   : none (package).
package ps2_kbd_pkg;

   // FSM state encoding (legacy-compatible constants)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   // Prefix bytes
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;

   // Keyboard housekeeping bytes that never form part of a key event
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   // Modifier and special scancodes
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [7:0] SC_CTRL    = 8'h14;
   localparam logic [7:0] SC_ALT     = 8'h11;
   localparam logic [7:0] SC_ENTER   = 8'h5A;
   localparam logic [7:0] SC_SPACE   = 8'h29;

   typedef struct packed {
      logic [7:0] scan;
      logic       ext;
      logic       brk;
      logic [7:0] ascii;
   } ps2_evt_t;

   localparam int EVT_W = $bits(ps2_evt_t);

   function automatic logic is_ignored_byte(input logic [7:0] b);
      return (b == PS2_PAUSE) || (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND);
   endfunction

   // Enter maps to CR for both the main and keypad (E0 5A) keys; every other
   // extended key and every release has no character.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] scan, input logic ext,
                                                input logic brk, input logic shift);
      logic [7:0] lc;
      logic [7:0] res;
      lc  = 8'h00;
      res = 8'h00;
      case (scan)
         8'h1C: lc = "a";
         8'h32: lc = "b";
         8'h21: lc = "c";
         8'h23: lc = "d";
         8'h24: lc = "e";
         8'h2B: lc = "f";
         8'h34: lc = "g";
         8'h33: lc = "h";
         8'h43: lc = "i";
         8'h3B: lc = "j";
         8'h42: lc = "k";
         8'h4B: lc = "l";
         8'h3A: lc = "m";
         8'h31: lc = "n";
         8'h44: lc = "o";
         8'h4D: lc = "p";
         8'h15: lc = "q";
         8'h2D: lc = "r";
         8'h1B: lc = "s";
         8'h2C: lc = "t";
         8'h3C: lc = "u";
         8'h2A: lc = "v";
         8'h1D: lc = "w";
         8'h22: lc = "x";
         8'h35: lc = "y";
         8'h1A: lc = "z";
         default: lc = 8'h00;
      endcase
      if (brk) begin
         res = 8'h00;
      end else if (scan == SC_ENTER) begin
         res = 8'h0D;
      end else if (ext) begin
         res = 8'h00;
      end else if (lc != 8'h00) begin
         res = shift ? (lc - 8'h20) : lc;
      end else begin
         case (scan)
            8'h45:    res = "0";
            8'h16:    res = "1";
            8'h1E:    res = "2";
            8'h26:    res = "3";
            8'h25:    res = "4";
            8'h2E:    res = "5";
            8'h36:    res = "6";
            8'h3D:    res = "7";
            8'h3E:    res = "8";
            8'h46:    res = "9";
            SC_SPACE: res = 8'h20;
            default:  res = 8'h00;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous event FIFO with valid/ready ports, pointer wrap and occupancy count
//
// Purpose : Buffers decoded key events between the decoder and its consumer.
//           A write while full is accepted only if a read happens in the same
//           cycle; otherwise it is refused (wr_accept=0) and the caller drops it.
// Ports   : clk, rst (async, active-low)
//           wr_valid/wr_data  in   : write request and payload
//           wr_accept         out  : write actually stored this cycle
//           rd_valid/rd_data  out  : head entry (rd_data is 0 while empty)
//           rd_ready          in   : consumer pops the head when rd_valid=1
module ps2_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_accept,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready
);
   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             do_pop;

   assign full      = (count == DEPTH_CNT);
   assign rd_valid  = (count != '0);
   assign do_pop    = rd_valid & rd_ready;
   // When full, the slot being popped is the one about to be written, so a
   // simultaneous push is safe.
   assign wr_accept = wr_valid & (~full | do_pop);
   assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_accept, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - set-2 PS/2 scancode decoder producing key events into a FIFO
//
// Purpose : Decodes make / break (F0) / extended (E0) sequences, tracks
//           shift/ctrl/alt, attaches ASCII and queues one event per key action.
//           Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeat makes.
// Ports   : clk, rst (async, active-low)
//           ps2_data[7:0], ps2_valid        in  : received byte + 1-cycle strobe
//           evt_ready                       in  : consumer pops head event
//           evt_valid, evt_scan, evt_ext,
//           evt_break, evt_ascii            out : head event of the FIFO
//           shift_flag, ctrl_flag, alt_flag out : modifier held state
//           key_cnt[CNT_W-1:0]              out : make events written (wraps)
//           fifo_ovf                        out : sticky event-dropped flag
module ps2_key_decoder
   import ps2_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_valid,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [7:0]       evt_scan,
   output logic             evt_ext,
   output logic             evt_break,
   output logic [7:0]       evt_ascii,
   output logic             shift_flag,
   output logic             ctrl_flag,
   output logic             alt_flag,
   output logic [CNT_W-1:0] key_cnt,
   output logic             fifo_ovf
);
   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       emit;
   logic       emit_ext;
   logic       emit_brk;
   logic [7:0] emit_ascii;
   logic       suppress;

   // Left/right variants tracked separately so releasing one side does not
   // clear a modifier still held on the other.
   logic       lshift_q, rshift_q;
   logic       lctrl_q,  rctrl_q;
   logic       lalt_q,   ralt_q;

   // One-entry stage between decode and FIFO write
   logic       pend_valid_q;
   ps2_evt_t   pend_evt_q;

   logic       wr_accept;
   ps2_evt_t   head_evt;

   assign shift_flag = lshift_q | rshift_q;
   assign ctrl_flag  = lctrl_q  | rctrl_q;
   assign alt_flag   = lalt_q   | ralt_q;

   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (ps2_valid) begin
         if (is_ignored_byte(ps2_data)) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ps2_data == PS2_EXT) begin
                     state_d = ST_EXT;
                  end else if (ps2_data == PS2_BRK) begin
                     state_d = ST_BRK;
                  end else begin
                     emit = 1'b1;
                  end
               end
               ST_EXT: begin
                  if (ps2_data == PS2_BRK) begin
                     state_d = ST_EXT_BRK;
                  end else if (ps2_data != PS2_EXT) begin
                     emit     = 1'b1;
                     emit_ext = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end
               ST_BRK: begin
                  if (ps2_data != PS2_BRK) begin
                     emit     = 1'b1;
                     emit_brk = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end
               default: begin
                  if (ps2_data != PS2_BRK) begin
                     emit     = 1'b1;
                     emit_ext = 1'b1;
                     emit_brk = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Shift as held before this byte's own modifier update
   assign emit_ascii = scan_to_ascii(ps2_data, emit_ext, emit_brk, shift_flag);

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       last_vld_q;
   logic [7:0] last_scan_q;
   logic       last_ext_q;

   assign suppress = emit & ~emit_brk & last_vld_q &
                     (last_scan_q == ps2_data) & (last_ext_q == emit_ext);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_vld_q  <= 1'b0;
         last_scan_q <= 8'h00;
         last_ext_q  <= 1'b0;
      end else if (emit) begin
         last_vld_q  <= ~emit_brk;
         last_scan_q <= ps2_data;
         last_ext_q  <= emit_ext;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         pend_valid_q <= 1'b0;
         pend_evt_q   <= '0;
         lshift_q     <= 1'b0;
         rshift_q     <= 1'b0;
         lctrl_q      <= 1'b0;
         rctrl_q      <= 1'b0;
         lalt_q       <= 1'b0;
         ralt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= emit & ~suppress;
         if (emit) begin
            pend_evt_q <= '{scan: ps2_data, ext: emit_ext, brk: emit_brk, ascii: emit_ascii};
            if (!emit_ext) begin
               case (ps2_data)
                  SC_LSHIFT: lshift_q <= ~emit_brk;
                  SC_RSHIFT: rshift_q <= ~emit_brk;
                  SC_CTRL:   lctrl_q  <= ~emit_brk;
                  SC_ALT:    lalt_q   <= ~emit_brk;
                  default:   ;
               endcase
            end else begin
               case (ps2_data)
                  SC_CTRL:   rctrl_q  <= ~emit_brk;
                  SC_ALT:    ralt_q   <= ~emit_brk;
                  default:   ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_cnt  <= '0;
         fifo_ovf <= 1'b0;
      end else begin
         if (wr_accept && !pend_evt_q.brk) begin
            key_cnt <= key_cnt + 1'b1;
         end
         if (pend_valid_q && !wr_accept) begin
            fifo_ovf <= 1'b1;
         end
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (pend_valid_q),
      .wr_data   (pend_evt_q),
      .wr_accept (wr_accept),
      .rd_valid  (evt_valid),
      .rd_data   (head_evt),
      .rd_ready  (evt_ready)
   );

   assign evt_scan  = head_evt.scan;
   assign evt_ext   = head_evt.ext;
   assign evt_break = head_evt.brk;
   assign evt_ascii = head_evt.ascii;

endmodule
